// File: rtl/mul_seq_if.sv
// Operand/result bundle for the sequential 4x4 multiplier.
// Both sides use a valid/ready handshake, and there is no clock in the bundle.
// The master drives the operands and out_ready. The slave drives the product and status.
interface mul_seq_if;
    logic [3:0] a;
    logic [3:0] b;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] y;
    logic       out_valid;
    logic       out_ready;
    logic       busy;

    // Upstream requester / product consumer
    modport master (
        output a, b, in_valid, out_ready,
        input  in_ready, y, out_valid, busy
    );

    // Multiplier side
    modport slave (
        input  a, b, in_valid, out_ready,
        output in_ready, y, out_valid, busy
    );
endinterface

// File: rtl/mul_seq.sv
// Sequential 4x4 unsigned shift-add multiplier with valid/ready on both sides (optional macro MUL_ZERO_SKIP_EN).
// Latency is 4 edges from the accept edge to out_valid. With MUL_ZERO_SKIP_EN and a zero operand, out_valid rises right after the accept edge.
// Backpressure: DONE holds y/out_valid stable until out_ready, and no new operands are taken before then.
module mul_seq (
    input  logic       clk,
    input  logic       rst,
    mul_seq_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic [7:0] r_mcand;     // multiplicand, shifted left each bit
    logic [3:0] r_mplier;    // multiplier, consumed LSB first
    logic [7:0] r_acc;       // partial sum; 15*15 = 225 fits in 8 bits
    logic [1:0] r_cnt;       // bit index being processed in CALC
    logic [7:0] r_y;         // last completed product

    logic       w_accept;
    logic       w_deliver;
    logic       w_last;
    logic       w_zero;
    logic [7:0] w_addend;
    logic [7:0] w_acc_sum;
    logic       w_in_ready;
    logic       w_out_valid;
    logic       w_busy;

    assign w_accept  = bus.in_valid  & (r_state == S_IDLE);
    assign w_deliver = bus.out_ready & (r_state == S_DONE);
    assign w_last    = (r_cnt == 2'd3);
    assign w_addend  = r_mplier[0] ? r_mcand : 8'h00;
    assign w_acc_sum = r_acc + w_addend;

`ifdef MUL_ZERO_SKIP_EN
    // A zero operand makes the product known at acceptance, so CALC can be bypassed.
    assign w_zero = (bus.a == 4'd0) | (bus.b == 4'd0);
`else
    assign w_zero = 1'b0;
`endif

    // State register; reset wins over any handshake in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state selection
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_zero ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (w_deliver) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Handshake/status outputs decoded from state; accept and deliver are mutually exclusive
    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            S_IDLE: w_in_ready = 1'b1;
            S_CALC: w_busy     = 1'b1;
            S_DONE: begin
                w_out_valid = 1'b1;
                w_busy      = 1'b1;
            end
            default: w_in_ready = 1'b0;
        endcase
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.y         = r_y;

    // Datapath: load the operands on accept, then add and shift one multiplier bit per CALC cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= 8'h00;
            r_mplier <= 4'h0;
            r_acc    <= 8'h00;
            r_cnt    <= 2'd0;
            r_y      <= 8'h00;
        end else if (w_accept) begin
            r_mcand  <= {4'b0000, bus.a};
            r_mplier <= bus.b;
            r_acc    <= 8'h00;
            r_cnt    <= 2'd0;
            if (w_zero) begin
                r_y <= 8'h00;
            end
        end else if (r_state == S_CALC) begin
            r_acc    <= w_acc_sum;
            r_mcand  <= {r_mcand[6:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[3:1]};
            r_cnt    <= r_cnt + 2'd1;
            if (w_last) begin
                // The final partial sum goes straight to y, so DONE shows the product on entry.
                r_y <= w_acc_sum;
            end
        end
    end

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: transaction-level model plus directed and random operations.
module tb_mul_seq;

`ifdef MUL_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic clk;
    logic rst;
    mul_seq_if bus();

    mul_seq dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_done = 0;
    int dut_deliv = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Behavioural model: per operation, either a countdown of edges left before the
    // product appears, or a held product waiting to be taken.
    int         m_left = 0;
    bit         m_hold = 1'b0;
    logic [7:0] m_y    = 8'h00;
    logic [7:0] m_prod = 8'h00;
    bit         m_live = 1'b0;
    int         m_deliv = 0;

    always @(posedge clk) begin
        m_live <= 1'b1;
        if (rst) begin
            m_left <= 0;
            m_hold <= 1'b0;
            m_y    <= 8'h00;
        end else if (m_left == 0 && !m_hold) begin
            if (bus.in_valid) begin
                if (SKIP && (bus.a == 4'd0 || bus.b == 4'd0)) begin
                    m_hold <= 1'b1;
                    m_y    <= 8'h00;
                end else begin
                    m_left <= 4;
                    m_prod <= 8'(bus.a) * 8'(bus.b);
                end
            end
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_hold <= 1'b1;
                m_y    <= m_prod;
            end
        end else if (bus.out_ready) begin
            m_hold  <= 1'b0;
            m_deliv <= m_deliv + 1;
        end
    end

    // Compare process: every cycle, away from the active edge
    always @(negedge clk) begin
        if (m_live) begin
            chk("in_ready",  {7'd0, bus.in_ready},  {7'd0, (m_left == 0 && !m_hold)});
            chk("out_valid", {7'd0, bus.out_valid}, {7'd0, m_hold});
            chk("busy",      {7'd0, bus.busy},      {7'd0, (m_left != 0 || m_hold)});
            chk("y",         bus.y,                 m_y);
            if (!rst && bus.out_valid && bus.out_ready) dut_deliv++;
        end
    end

    // One operation starting at #1 after an edge with the DUT idle.
    // lat = edges after the accept edge until out_valid is seen.
    task automatic run_op(input logic [3:0] ta, input logic [3:0] tbv, input int stall,
                          input bit junk, output logic [7:0] ry, output int lat);
        bus.a = ta;
        bus.b = tbv;
        bus.in_valid  = 1'b1;
        bus.out_ready = (stall == 0);
        @(posedge clk); #1;
        bus.in_valid = junk;
        if (junk) begin
            bus.a = 4'd15;
            bus.b = 4'd15;
        end
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            if (junk) chk("calc_in_ready", {7'd0, bus.in_ready}, 8'd0);
            @(posedge clk); #1;
            lat++;
        end
        bus.in_valid = 1'b0;
        if (!bus.out_valid) begin
            checks++;
            errors++;
            $display("FAIL timeout: out_valid=%0b required 1 within 20 edges", bus.out_valid);
        end
        ry = bus.y;
        for (int i = 0; i < stall; i++) begin
            bus.in_valid = 1'b1;
            bus.a = 4'($urandom_range(15, 0));
            bus.b = 4'($urandom_range(15, 0));
            @(posedge clk); #1;
            chk("hold_valid", {7'd0, bus.out_valid}, 8'd1);
            chk("hold_y", bus.y, ry);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("idle_after_deliver", {7'd0, bus.in_ready}, 8'd1);
        n_done++;
    endtask

    initial begin
        logic [7:0] ry;
        int lat;
        logic [3:0] ra, rb;
        int st;

        rst = 1'b1;
        bus.a = 4'd0;
        bus.b = 4'd0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_in_ready",  {7'd0, bus.in_ready},  8'd1);
        chk("rst_out_valid", {7'd0, bus.out_valid}, 8'd0);
        chk("rst_busy",      {7'd0, bus.busy},      8'd0);
        chk("rst_y",         bus.y,                 8'h00);

        // Max product
        run_op(4'd15, 4'd15, 0, 1'b0, ry, lat);
        chk("max_y", ry, 8'hE1);
        chk("max_lat", 8'(lat), 8'd4);

        // Backpressure: held 5 cycles while new operands are offered
        run_op(4'd9, 4'd6, 5, 1'b0, ry, lat);
        chk("bp_y", ry, 8'h36);
        chk("bp_lat", 8'(lat), 8'd4);

        // Operands driven during CALC are ignored
        run_op(4'd3, 4'd5, 0, 1'b1, ry, lat);
        chk("ign_y", ry, 8'h0F);

        // Reset asserted so that it is sampled at E2
        bus.a = 4'd7;
        bus.b = 4'd7;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid_idle", {7'd0, bus.in_ready}, 8'd1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("rst_mid_no_valid", {7'd0, bus.out_valid}, 8'd0);
        end
        run_op(4'd2, 4'd3, 0, 1'b0, ry, lat);
        chk("after_rst_y", ry, 8'h06);
        chk("after_rst_lat", 8'(lat), 8'd4);

        // Zero operand
        run_op(4'd0, 4'd9, 0, 1'b0, ry, lat);
        chk("zero_y", ry, 8'h00);
        chk("zero_lat", 8'(lat), SKIP ? 8'd0 : 8'd4);

        // Random operations with random stalls and idle gaps
        for (int n = 0; n < 40; n++) begin
            ra = 4'($urandom_range(15, 0));
            rb = 4'($urandom_range(15, 0));
            if (n % 8 == 0) ra = 4'd0;
            st = $urandom_range(3, 0);
            run_op(ra, rb, st, 1'($urandom_range(1, 0)), ry, lat);
            chk("rand_y", ry, 8'(ra) * 8'(rb));
            chk("rand_lat", 8'(lat), (SKIP && (ra == 4'd0 || rb == 4'd0)) ? 8'd0 : 8'd4);
            repeat ($urandom_range(2, 0)) @(posedge clk);
            #1;
        end

        repeat (3) @(posedge clk);
        #1;
        chk("deliv_dut", 8'(dut_deliv), 8'(n_done));
        chk("deliv_model", 8'(m_deliv), 8'(n_done));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
